// File: rtl/adder_pipe_pkg.sv
// Shared types and sizing helpers for the windowed sum accumulator.
package adder_pipe_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int WINDOW_COUNT_WIDTH = 16;

    // One extra bit per doubling of the window keeps the total exact.
    function automatic int acc_width(input int adder_width, input int window_log2);
        return adder_width + 1 + window_log2;
    endfunction

endpackage

// File: rtl/adder_sum_accum_if.sv
// Sample stream in, window-total result slot out, plus status/control.
interface adder_sum_accum_if
    import adder_pipe_pkg::*;
#(
    parameter int ADDER_WIDTH = 32,
    parameter int WINDOW_LOG2 = 4
);
    localparam int ACC_WIDTH = acc_width(ADDER_WIDTH, WINDOW_LOG2);

    logic                          en;
    logic [ADDER_WIDTH:0]          sum_in;
    logic                          sum_valid;
    logic [ACC_WIDTH-1:0]          acc_out;
    logic                          acc_valid;
    logic                          acc_ready;
    logic                          overrun;
    logic                          overrun_clr;
    logic [WINDOW_COUNT_WIDTH-1:0] window_count;

    modport master (
        output en, sum_in, sum_valid, acc_ready, overrun_clr,
        input  acc_out, acc_valid, overrun, window_count
    );

    modport slave (
        input  en, sum_in, sum_valid, acc_ready, overrun_clr,
        output acc_out, acc_valid, overrun, window_count
    );

endinterface

// File: rtl/sum_window_counter.sv
// Sample position within the current window; last flags the final slot.
module sum_window_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic last
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last = &count;

endmodule

// File: rtl/adder_sum_accum.sv
// Accumulates fixed windows of adder sums and offers each total on a
// single-entry valid/ready slot; totals that find the slot busy are dropped.
//
// state | meaning
// IDLE  | not accumulating; accumulator and counter held at zero
// ACCUM | summing samples of the current window
module adder_sum_accum
    import adder_pipe_pkg::*;
#(
    parameter int ADDER_WIDTH = 32,
    parameter int WINDOW_LOG2 = 4
) (
    input  logic clk,
    input  logic rst_n,
    adder_sum_accum_if.slave bus
);
    localparam int ACC_WIDTH = acc_width(ADDER_WIDTH, WINDOW_LOG2);

    state_t               state, state_next;
    logic [ACC_WIDTH-1:0] acc, acc_next;
    logic [ACC_WIDTH-1:0] sum_ext;
    logic [ACC_WIDTH-1:0] result;
    logic                 cnt_clear, cnt_inc, cnt_last;
    logic                 complete;
    logic                 transfer, slot_free;

    sum_window_counter #(.WIDTH(WINDOW_LOG2)) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .last  (cnt_last)
    );

    assign sum_ext   = ACC_WIDTH'(bus.sum_in);
    assign transfer  = bus.acc_valid && bus.acc_ready;
    assign slot_free = !bus.acc_valid || bus.acc_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        complete   = 1'b0;
        result     = '0;
        case (state)
            IDLE: begin
                // Counter is already zero here, so the first sample is slot 0.
                if (bus.en && bus.sum_valid) begin
                    state_next = ACCUM;
                    acc_next   = sum_ext;
                    cnt_inc    = 1'b1;
                end
            end
            ACCUM: begin
                if (!bus.en) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    cnt_clear  = 1'b1;
                end else if (bus.sum_valid) begin
                    if (cnt_last) begin
                        complete  = 1'b1;
                        result    = acc + sum_ext;
                        acc_next  = '0;
                        cnt_clear = 1'b1;
                    end else begin
                        acc_next = acc + sum_ext;
                        cnt_inc  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                acc_next   = '0;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.acc_out      <= '0;
            bus.acc_valid    <= 1'b0;
            bus.overrun      <= 1'b0;
            bus.window_count <= '0;
        end else begin
            if (complete && slot_free) begin
                bus.acc_out   <= result;
                bus.acc_valid <= 1'b1;
            end else if (transfer) begin
                bus.acc_valid <= 1'b0;
            end

            if (transfer) begin
                bus.window_count <= bus.window_count + 1'b1;
            end

            // A drop in the same cycle as a clear must leave the flag set.
            if (complete && !slot_free) begin
                bus.overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                bus.overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_sum_accum.sv
// Directed window scenarios plus randomized traffic against a queue-based model.
module tb_adder_sum_accum;
    localparam int AW   = 8;
    localparam int WL   = 2;
    localparam int N    = 1 << WL;
    localparam int MAXS = 510;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_sum_accum_if #(.ADDER_WIDTH(AW), .WINDOW_LOG2(WL)) bus();

    adder_sum_accum #(.ADDER_WIDTH(AW), .WINDOW_LOG2(WL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    int q[$];
    int m_out   = 0;
    bit m_valid = 1'b0;
    bit m_ovr   = 1'b0;
    int m_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Window semantics: samples collect while enabled, a full window yields
    // its arithmetic sum, disabling or reset throws away the partial window.
    task automatic model_edge();
        bit complete;
        bit xfer;
        int res;
        complete = 1'b0;
        res = 0;
        if (!rst_n) begin
            q.delete();
            m_out = 0; m_valid = 1'b0; m_ovr = 1'b0; m_cnt = 0;
            return;
        end
        if (!bus.en) begin
            q.delete();
        end else if (bus.sum_valid) begin
            q.push_back(int'(bus.sum_in));
            if (q.size() == N) begin
                complete = 1'b1;
                res = q.sum();
                q.delete();
            end
        end
        xfer = m_valid && bus.acc_ready;
        if (xfer) m_cnt = (m_cnt + 1) % 65536;
        if (bus.overrun_clr) m_ovr = 1'b0;
        if (complete) begin
            if (!m_valid || bus.acc_ready) begin
                m_out = res;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (xfer) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic cyc(input bit e, input bit v, input int s, input bit r, input bit c);
        bus.en          = e;
        bus.sum_valid   = v;
        bus.sum_in      = s[AW:0];
        bus.acc_ready   = r;
        bus.overrun_clr = c;
        @(posedge clk);
        model_edge();
        #1;
        chk("acc_valid", 32'(bus.acc_valid), 32'(m_valid));
        chk("acc_out", 32'(bus.acc_out), 32'(m_out));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
        chk("window_count", 32'(bus.window_count), 32'(m_cnt));
    endtask

    task automatic window(input int a, input int b, input int c, input int d, input bit r);
        cyc(1, 1, a, r, 0);
        cyc(1, 1, b, r, 0);
        cyc(1, 1, c, r, 0);
        cyc(1, 1, d, r, 0);
    endtask

    initial begin
        bus.en = 0; bus.sum_valid = 0; bus.sum_in = '0;
        bus.acc_ready = 0; bus.overrun_clr = 0;
        rst_n = 0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("reset_out", 32'(bus.acc_out), 0);
        chk("reset_valid", 32'(bus.acc_valid), 0);
        rst_n = 1;

        // basic window
        window(1, 2, 3, 4, 1);
        chk("basic_out", 32'(bus.acc_out), 10);
        chk("basic_valid", 32'(bus.acc_valid), 1);
        cyc(1, 0, 0, 1, 0);
        chk("basic_drop", 32'(bus.acc_valid), 0);
        chk("basic_count", 32'(bus.window_count), 1);

        // gapped valid
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 1, i, 1, 0);
            if (i < 4) begin
                cyc(1, 0, 0, 1, 0);
                cyc(1, 0, 0, 1, 0);
            end
        end
        chk("gap_out", 32'(bus.acc_out), 10);
        chk("gap_valid", 32'(bus.acc_valid), 1);

        // max values, no wrap
        window(MAXS, MAXS, MAXS, MAXS, 1);
        chk("max_out", 32'(bus.acc_out), 2040);
        cyc(1, 0, 0, 1, 0);

        // overrun: second window dropped while slot is held
        window(1, 2, 3, 4, 0);
        window(5, 6, 7, 8, 0);
        chk("ovr_out", 32'(bus.acc_out), 10);
        chk("ovr_flag", 32'(bus.overrun), 1);
        cyc(1, 0, 0, 1, 0);
        chk("ovr_drained", 32'(bus.acc_valid), 0);
        cyc(1, 0, 0, 0, 1);
        chk("ovr_clr", 32'(bus.overrun), 0);

        // simultaneous transfer and load
        window(1, 2, 3, 4, 0);
        cyc(1, 1, 5, 0, 0);
        cyc(1, 1, 6, 0, 0);
        cyc(1, 1, 7, 0, 0);
        cyc(1, 1, 8, 1, 0);
        chk("sim_out", 32'(bus.acc_out), 26);
        chk("sim_valid", 32'(bus.acc_valid), 1);
        chk("sim_ovr", 32'(bus.overrun), 0);
        cyc(1, 0, 0, 1, 0);

        // disable mid-window
        cyc(1, 1, 5, 1, 0);
        cyc(1, 1, 5, 1, 0);
        cyc(0, 1, 9, 1, 0);
        window(1, 1, 1, 1, 1);
        chk("dis_out", 32'(bus.acc_out), 4);
        cyc(1, 0, 0, 1, 0);

        // reset mid-window
        cyc(1, 1, 5, 1, 0);
        cyc(1, 1, 5, 1, 0);
        rst_n = 0;
        cyc(1, 1, 5, 1, 0);
        rst_n = 1;
        chk("rst_out", 32'(bus.acc_out), 0);
        chk("rst_count", 32'(bus.window_count), 0);
        window(1, 1, 1, 1, 1);
        chk("rst_win", 32'(bus.acc_out), 4);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            cyc($urandom_range(0, 19) != 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, MAXS),
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0);
        end
        rst_n = 1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
